// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Table-driven phase sequencer for the countdown timer.
//               Steps through up to DEPTH programmed phases. Each phase loads
//               the timer with its preset, drives its output pattern and
//               waits for timer_done before moving on.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               cfg_we/addr/preset/out/last - host table write port
//               start, abort       - run request / synchronous stop
//               timer_done         - done from the downstream timer
//               timer_load/preset  - registered load pulse and preset
//               phase_out          - current phase pattern
//               phase_idx          - current table entry
//               busy, seq_done     - running flag, completion pulse
//               loops              - extra pass count (PHASE_SEQ_LOOP_EN only)
// Options     : PHASE_SEQ_LOOP_EN - adds the loops input and repeat passes
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
   parameter int                 WIDTH    = 16,
   parameter int                 OUT_W    = 8,
   parameter int                 DEPTH    = 8,
   parameter int                 AW       = 3,
   parameter logic [OUT_W-1:0]   IDLE_OUT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [WIDTH-1:0] cfg_preset,
   input  logic [OUT_W-1:0] cfg_out,
   input  logic             cfg_last,
   input  logic             start,
   input  logic             abort,
   input  logic             timer_done,
`ifdef PHASE_SEQ_LOOP_EN
   input  logic [7:0]       loops,
`endif
   output logic             timer_load,
   output logic [WIDTH-1:0] timer_preset,
   output logic [OUT_W-1:0] phase_out,
   output logic [AW-1:0]    phase_idx,
   output logic             busy,
   output logic             seq_done
);

   // WAIT is split into its first cycle (timer_done ignored, it may still
   // reflect the previous phase) and the remaining cycles.
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD       = 3'd1,
      S_WAIT_FIRST = 3'd2,
      S_WAIT       = 3'd3,
      S_FINISH     = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic               last_q, last_d;
   logic               load_q, load_d;
   logic [WIDTH-1:0]   preset_q, preset_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef PHASE_SEQ_LOOP_EN
   logic [7:0]         loops_q, loops_d;
`endif

   logic               load_now;
   logic [AW-1:0]      load_idx;

   // Phase table: not reset, host programs it before the first run.
   logic [WIDTH-1:0]   tbl_preset_q [DEPTH];
   logic [OUT_W-1:0]   tbl_out_q    [DEPTH];
   logic               tbl_last_q   [DEPTH];

   always_ff @(posedge clk) begin
      if (cfg_we) begin
         tbl_preset_q[cfg_addr] <= cfg_preset;
         tbl_out_q[cfg_addr]    <= cfg_out;
         tbl_last_q[cfg_addr]   <= cfg_last;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      load_d   = 1'b0;
      preset_d = preset_q;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef PHASE_SEQ_LOOP_EN
      loops_d  = loops_q;
`endif
      load_now = 1'b0;
      load_idx = idx_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               load_now = 1'b1;
               load_idx = '0;
`ifdef PHASE_SEQ_LOOP_EN
               loops_d  = loops;
`endif
            end
         end
         S_LOAD: begin
            state_d = S_WAIT_FIRST;
         end
         S_WAIT_FIRST: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (timer_done) begin
               if (!last_q) begin
                  load_now = 1'b1;
                  load_idx = idx_q + 1'b1;
               end
`ifdef PHASE_SEQ_LOOP_EN
               else if (loops_q != 8'd0) begin
                  // Straight back to entry 0, no idle gap between passes.
                  loops_d  = loops_q - 8'd1;
                  load_now = 1'b1;
                  load_idx = '0;
               end
`endif
               else begin
                  state_d = S_FINISH;
                  out_d   = IDLE_OUT;
                  done_d  = 1'b1;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            out_d   = IDLE_OUT;
            busy_d  = 1'b0;
         end
      endcase

      // The table entry is sampled only here, on the edge entering LOAD,
      // so writes to entries not yet reached affect the current run.
      if (load_now) begin
         state_d  = S_LOAD;
         idx_d    = load_idx;
         load_d   = 1'b1;
         preset_d = tbl_preset_q[load_idx];
         out_d    = tbl_out_q[load_idx];
         last_d   = tbl_last_q[load_idx] || (load_idx == AW'(DEPTH - 1));
         busy_d   = 1'b1;
      end

      // Abort overrides everything, including timer_done and looping.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         idx_d   = idx_q;
         load_d  = 1'b0;
         out_d   = IDLE_OUT;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         last_q   <= 1'b0;
         load_q   <= 1'b0;
         preset_q <= '0;
         out_q    <= IDLE_OUT;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef PHASE_SEQ_LOOP_EN
         loops_q  <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         load_q   <= load_d;
         preset_q <= preset_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef PHASE_SEQ_LOOP_EN
         loops_q  <= loops_d;
`endif
      end
   end

   assign timer_load   = load_q;
   assign timer_preset = preset_q;
   assign phase_out    = out_q;
   assign phase_idx    = idx_q;
   assign busy         = busy_q;
   assign seq_done     = done_q;

endmodule
`default_nettype wire
